// File: rtl/gradient_pkg.sv
// Shared types and width helper for the multi-channel gradient weighter.
// The mode encoding matches the external mode pin: 0 smooths, 1 differences.
package gradient_pkg;

  typedef enum logic {
    GW_SMOOTH = 1'b0,
    GW_DIFF   = 1'b1
  } gw_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    PHASE1,
    PHASE2,
    DONE
  } gw_state_t;

  // Result width: two guard bits cover the x4 worst-case gain of [1 2 1].
  function automatic int gw_out_width(input int bits);
    return bits + 2;
  endfunction

endpackage

// File: rtl/gradient_weight_seq_addsub_2.sv
// Combinational signed adder/subtractor shared by every channel and phase.
module addsub_2 #(
  parameter int BITS = 10
) (
  input  logic signed [BITS-1:0] a,
  input  logic signed [BITS-1:0] b,
  input  logic                   sub,
  output logic signed [BITS-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/gradient_weight_seq.sv
// Multi-channel 3-tap gradient weighter: one shared add/sub unit, two cycles
// per channel, valid/ready handshake on both sides.
module gradient_weight_seq
  import gradient_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int CHANNELS = 3
) (
  input  logic                                                clk,
  input  logic                                                n_rst,
  input  logic                                                mode,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic signed [CHANNELS-1:0][2:0][BITS-1:0]           in_pixels,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic signed [CHANNELS-1:0][gw_out_width(BITS)-1:0]  out_pixels,
  output logic                                                busy
);

  localparam int            OW      = gw_out_width(BITS);
  localparam int            CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  gw_state_t state, state_next;
  gw_mode_t  mode_q;

  logic [CHANNELS-1:0][2:0][BITS-1:0] pix_q;
  logic [CW-1:0]                      ch;
  logic signed [OW-1:0]               temp;
  logic signed [OW-1:0]               p0_x, p1_x, p2_x;
  logic signed [OW-1:0]               op_a, op_b, sum;
  logic                               op_sub;
  logic                               accept;

  assign accept = (state == IDLE) && in_valid;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = PHASE1;
      PHASE1:                 state_next = PHASE2;
      PHASE2:  state_next = (ch == LAST_CH) ? DONE : PHASE1;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // NOTE: captured operands need no reset; they are only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_q  <= in_pixels;
      mode_q <= gw_mode_t'(mode);
    end
  end

  assign p0_x = {{2{pix_q[ch][0][BITS-1]}}, pix_q[ch][0]};
  assign p1_x = {{2{pix_q[ch][1][BITS-1]}}, pix_q[ch][1]};
  assign p2_x = {{2{pix_q[ch][2][BITS-1]}}, pix_q[ch][2]};

  // PHASE1 forms the partial term, PHASE2 folds in the last tap (or zero for DIFF).
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    case (state)
      PHASE1: begin
        if (mode_q == GW_DIFF) begin
          op_a   = p2_x;
          op_b   = p0_x;
          op_sub = 1'b1;
        end else begin
          op_a = p0_x;
          op_b = p1_x <<< 1;
        end
      end
      PHASE2: begin
        op_a = temp;
        op_b = (mode_q == GW_SMOOTH) ? p2_x : '0;
      end
      default: ;
    endcase
  end

  addsub_2 #(.BITS(OW)) u_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ch         <= '0;
      temp       <= '0;
      out_pixels <= '0;
    end else begin
      case (state)
        IDLE:   if (in_valid) ch <= '0;
        PHASE1: temp <= sum;
        PHASE2: begin
          out_pixels[ch] <= sum;
          if (ch != LAST_CH) ch <= ch + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gradient_weight_seq.sv
// Bench for gradient_weight_seq: transaction-level reference model with a
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_gradient_weight_seq;

  localparam int B  = 8;
  localparam int C  = 3;
  localparam int OW = B + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     n_rst, mode, in_valid, in_ready, out_valid, out_ready, busy;
  logic [C-1:0][2:0][B-1:0] in_pixels;
  logic [C-1:0][OW-1:0]     out_pixels;

  logic                     mode1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [0:0][2:0][B-1:0]   in_pixels1;
  logic [0:0][OW-1:0]       out_pixels1;

  gradient_weight_seq #(.BITS(B), .CHANNELS(C)) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixels(out_pixels), .busy(busy)
  );

  gradient_weight_seq #(.BITS(B), .CHANNELS(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .mode(mode1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_pixels(in_pixels1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_pixels(out_pixels1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [B-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ox(input logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference model: cyc is the cycle number within the transaction
  // (0 = idle, 1..2C = computing, 2C+1 = result offered).
  int cyc = 0;
  int res[C];
  int exp_out[C];
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (!n_rst) begin
      cyc = 0;
      foreach (exp_out[k]) exp_out[k] = 0;
    end else if (cyc == 0) begin
      if (in_valid) begin
        for (int k = 0; k < C; k++) begin
          if (mode) res[k] = sx(in_pixels[k][2]) - sx(in_pixels[k][0]);
          else      res[k] = sx(in_pixels[k][0]) + 2 * sx(in_pixels[k][1]) + sx(in_pixels[k][2]);
        end
        cyc = 1;
      end
    end else if (cyc <= 2 * C) begin
      if (cyc % 2 == 0) exp_out[cyc/2 - 1] = res[cyc/2 - 1];
      cyc++;
    end else if (out_ready) begin
      cyc = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", int'(in_ready), int'(cyc == 0));
      check("busy", int'(busy), int'(cyc != 0));
      check("out_valid", int'(out_valid), int'(cyc == 2 * C + 1));
      for (int k = 0; k < C; k++) check($sformatf("out_pixels[%0d]", k), ox(out_pixels[k]), exp_out[k]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int k, input int a, input int b, input int c);
    in_pixels[k][0] = a[B-1:0];
    in_pixels[k][1] = b[B-1:0];
    in_pixels[k][2] = c[B-1:0];
  endtask

  // Accepts one transaction and returns the cycle number in which out_valid is seen.
  task automatic run_txn(input int md, output int lat);
    mode     = md[0];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    check("in_ready_low_after_accept", int'(in_ready), 0);
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("out_valid_seen", int'(out_valid), 1);
  endtask

  int lat;
  logic [C-1:0][OW-1:0] snap;

  initial begin
    n_rst = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pixels = '0;
    mode1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; in_pixels1 = '0;
    repeat (2) step();
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_out_pix0", ox(out_pixels[0]), 0);
    n_rst  = 1'b1;
    chk_en = 1'b1;

    // SMOOTH basic: 10+40+30, -5+0+5, 1-2+1
    set_px(0, 10, 20, 30); set_px(1, -5, 0, 5); set_px(2, 1, -1, 1);
    run_txn(0, lat);
    check("smooth_latency", lat, 7);
    check("smooth_ch0", ox(out_pixels[0]), 80);
    check("smooth_ch1", ox(out_pixels[1]), 0);
    check("smooth_ch2", ox(out_pixels[2]), 0);
    step();

    // SMOOTH extremes
    for (int k = 0; k < C; k++) set_px(k, -128, -128, -128);
    run_txn(0, lat);
    for (int k = 0; k < C; k++) check("smooth_min", ox(out_pixels[k]), -512);
    step();
    for (int k = 0; k < C; k++) set_px(k, 127, 127, 127);
    run_txn(0, lat);
    for (int k = 0; k < C; k++) check("smooth_max", ox(out_pixels[k]), 508);
    step();

    // DIFF extremes, p1 ignored
    set_px(0, -128, 99, 127); set_px(1, 127, 99, -128); set_px(2, 3, 99, -7);
    run_txn(1, lat);
    check("diff_latency", lat, 7);
    check("diff_max", ox(out_pixels[0]), 255);
    check("diff_min", ox(out_pixels[1]), -255);
    check("diff_mid", ox(out_pixels[2]), -10);
    step();

    // Backpressure with ignored in_valid pulses and changing inputs
    set_px(0, 1, 2, 3); set_px(1, 4, 5, 6); set_px(2, -7, -8, -9);
    out_ready = 1'b0;
    run_txn(0, lat);
    snap = out_pixels;
    check("bp_ch2", ox(out_pixels[2]), -32);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      set_px(0, $urandom_range(0, 255), 0, 0);
      mode = ~mode;
      step();
      check("bp_hold_valid", int'(out_valid), 1);
      for (int k = 0; k < C; k++) check("bp_hold_pix", ox(out_pixels[k]), ox(snap[k]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_ready", int'(in_ready), 1);
    check("bp_release_valid", int'(out_valid), 0);

    // Reset mid-transaction (n_rst low sampled in cycle 3)
    set_px(0, 50, 1, 2); set_px(1, 3, 4, 5); set_px(2, 6, 7, 8);
    mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_rst = 1'b0;
    step();
    check("rst_mid_ready", int'(in_ready), 1);
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    for (int k = 0; k < C; k++) check("rst_mid_pix", ox(out_pixels[k]), 0);
    n_rst = 1'b1;
    set_px(0, -100, 7, 20); set_px(1, 0, 0, 0); set_px(2, 10, -3, -10);
    run_txn(1, lat);
    check("post_rst_ch0", ox(out_pixels[0]), 120);
    check("post_rst_ch1", ox(out_pixels[1]), 0);
    check("post_rst_ch2", ox(out_pixels[2]), -20);
    step();

    // Single-channel instance
    in_pixels1[0][0] = 8'd5; in_pixels1[0][1] = 8'd6; in_pixels1[0][2] = 8'd7;
    mode1 = 1'b0; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      step();
      lat++;
    end
    check("ch1_latency", lat, 3);
    check("ch1_result", ox(out_pixels1[0]), 24);
    step();
    check("ch1_idle", int'(in_ready1), 1);

    // Randomized traffic: inputs toggle every cycle, sporadic backpressure and resets
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      mode      = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      n_rst     = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < C; k++)
        set_px(k, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      step();
    end

    n_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    check("final_idle", int'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
